// File: rtl/cgra_exec_ctrl_if.sv
// Host/PE-array side signal bundle for the CGRA execution sequencer.
// The master drives the start handshake and kernel shape, while the slave drives the shared instruction address and status.
interface cgra_exec_ctrl_if #(
  parameter int IADDR_WIDTH = 10,
  parameter int ITER_WIDTH  = 16
);
  logic                   computation_start;
  logic [IADDR_WIDTH-1:0] inst_end;
  logic [ITER_WIDTH-1:0]  iter_num;
  logic                   stall;
  logic [IADDR_WIDTH-1:0] inst_addr;
  logic                   inst_valid;
  logic [ITER_WIDTH-1:0]  iter_cnt;
  logic                   pe_array_busy;
  logic                   computation_done;

  modport master (
    output computation_start, inst_end, iter_num, stall,
    input  inst_addr, inst_valid, iter_cnt, pe_array_busy, computation_done
  );

  modport slave (
    input  computation_start, inst_end, iter_num, stall,
    output inst_addr, inst_valid, iter_cnt, pe_array_busy, computation_done
  );
endinterface

// File: rtl/cgra_exec_ctrl.sv
// Execution sequencer for the SCGRA PE array: steps the shared instruction address
// over the kernel body for N iterations, drains the PE pipeline, then signals done.
module cgra_exec_ctrl #(
  parameter int IADDR_WIDTH  = 10,
  parameter int ITER_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  cgra_exec_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? DCW'(DRAIN_CYCLES - 1) : '0;

  logic [1:0]             state_q, state_d;
  logic [IADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ITER_WIDTH-1:0]  iter_q, iter_d;
  logic [DCW-1:0]         drain_q, drain_d;
  logic [IADDR_WIDTH-1:0] end_q;
  logic [ITER_WIDTH-1:0]  last_q;
  logic [ITER_WIDTH-1:0]  iter_last_in;
  logic                   latch_en;
  logic                   addr_at_end;
  logic                   iter_at_last;
  logic                   drain_at_last;

  // A zero iteration count runs the kernel once, so the last index is clamped at 0.
  assign iter_last_in  = (bus.iter_num == '0) ? '0 : (bus.iter_num - ITER_WIDTH'(1));
  assign latch_en      = (state_q == S_IDLE) && bus.computation_start;
  assign addr_at_end   = (addr_q == end_q);
  assign iter_at_last  = (iter_q == last_q);
  assign drain_at_last = (drain_q == DRAIN_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    iter_d  = iter_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (bus.computation_start) begin
          state_d = S_RUN;
          addr_d  = '0;
          iter_d  = '0;
          drain_d = '0;
        end
      end
      S_RUN: begin
        if (!bus.computation_start) begin
          state_d = S_IDLE;
          addr_d  = '0;
          iter_d  = '0;
          drain_d = '0;
        end else if (!bus.stall) begin
          if (!addr_at_end) begin
            addr_d = addr_q + IADDR_WIDTH'(1);
          end else if (!iter_at_last) begin
            addr_d = '0;
            iter_d = iter_q + ITER_WIDTH'(1);
          end else begin
            addr_d  = '0;
            drain_d = '0;
            state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!bus.computation_start) begin
          state_d = S_IDLE;
          addr_d  = '0;
          iter_d  = '0;
          drain_d = '0;
        end else if (drain_at_last) begin
          state_d = S_DONE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      default: begin
        // Done is held until software drops start; a start still high is not a new request.
        if (!bus.computation_start) begin
          state_d = S_IDLE;
          addr_d  = '0;
          iter_d  = '0;
          drain_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      iter_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      iter_q  <= iter_d;
      drain_q <= drain_d;
    end
  end

  // Kernel shape is captured only on acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      end_q  <= '0;
      last_q <= '0;
    end else if (latch_en) begin
      end_q  <= bus.inst_end;
      last_q <= iter_last_in;
    end
  end

  assign bus.inst_addr        = addr_q;
  assign bus.iter_cnt         = iter_q;
  assign bus.inst_valid       = (state_q == S_RUN) && !bus.stall;
  assign bus.pe_array_busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.computation_done = (state_q == S_DONE);

endmodule

// File: tb/tb_cgra_exec_ctrl.sv
// Directed bench for cgra_exec_ctrl: a DRAIN_CYCLES=4 instance for the main scenarios
// and a DRAIN_CYCLES=0 instance for the degenerate and full-memory cases.
module tb_cgra_exec_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cgra_exec_ctrl_if #(.IADDR_WIDTH(10), .ITER_WIDTH(16)) bus0 ();
  cgra_exec_ctrl_if #(.IADDR_WIDTH(10), .ITER_WIDTH(16)) bus1 ();

  cgra_exec_ctrl #(.IADDR_WIDTH(10), .ITER_WIDTH(16), .DRAIN_CYCLES(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  cgra_exec_ctrl #(.IADDR_WIDTH(10), .ITER_WIDTH(16), .DRAIN_CYCLES(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance into the next cycle; outputs are sampled 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.computation_start = 1'b0; bus0.inst_end = '0; bus0.iter_num = '0; bus0.stall = 1'b0;
    bus1.computation_start = 1'b0; bus1.inst_end = '0; bus1.iter_num = '0; bus1.stall = 1'b0;
    step();
    step();
    checks++;
    if ({bus0.inst_addr, bus0.iter_cnt, bus0.inst_valid, bus0.pe_array_busy, bus0.computation_done} !== 29'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut0 addr=%0d iter=%0d valid=%b busy=%b done=%b expected all 0",
               bus0.inst_addr, bus0.iter_cnt, bus0.inst_valid, bus0.pe_array_busy, bus0.computation_done);
    end
    checks++;
    if ({bus1.inst_addr, bus1.iter_cnt, bus1.inst_valid, bus1.pe_array_busy, bus1.computation_done} !== 29'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut1 addr=%0d iter=%0d valid=%b busy=%b done=%b expected all 0",
               bus1.inst_addr, bus1.iter_cnt, bus1.inst_valid, bus1.pe_array_busy, bus1.computation_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int exp_addr;
    int exp_iter;
    bus0.inst_end = 10'd3;
    bus0.iter_num = 16'd2;
    bus0.computation_start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c <= 8) begin
        exp_addr = (c - 1) % 4;
        exp_iter = (c - 1) / 4;
        checks++;
        if (bus0.inst_addr !== 10'(exp_addr) || bus0.iter_cnt !== 16'(exp_iter) ||
            bus0.inst_valid !== 1'b1 || bus0.pe_array_busy !== 1'b1 || bus0.computation_done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL basic_run c=%0d addr=%0d iter=%0d valid=%b busy=%b done=%b expected addr=%0d iter=%0d valid=1 busy=1 done=0",
                   c, bus0.inst_addr, bus0.iter_cnt, bus0.inst_valid, bus0.pe_array_busy, bus0.computation_done, exp_addr, exp_iter);
        end
      end else if (c <= 12) begin
        checks++;
        if (bus0.pe_array_busy !== 1'b1 || bus0.inst_valid !== 1'b0 || bus0.computation_done !== 1'b0 ||
            bus0.inst_addr !== 10'd0) begin
          errors++;
          $display("[TB] FAIL basic_drain c=%0d busy=%b valid=%b done=%b addr=%0d expected busy=1 valid=0 done=0 addr=0",
                   c, bus0.pe_array_busy, bus0.inst_valid, bus0.computation_done, bus0.inst_addr);
        end
      end else begin
        checks++;
        if (bus0.computation_done !== 1'b1 || bus0.pe_array_busy !== 1'b0 || bus0.inst_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL basic_done c=%0d done=%b busy=%b valid=%b expected done=1 busy=0 valid=0",
                   c, bus0.computation_done, bus0.pe_array_busy, bus0.inst_valid);
        end
      end
    end
    bus0.computation_start = 1'b0;
    step();
    checks++;
    if (bus0.computation_done !== 1'b0 || bus0.pe_array_busy !== 1'b0 || bus0.inst_addr !== 10'd0 || bus0.iter_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL basic_release done=%b busy=%b addr=%0d iter=%0d expected done=0 busy=0 addr=0 iter=0",
               bus0.computation_done, bus0.pe_array_busy, bus0.inst_addr, bus0.iter_cnt);
    end
  endtask

  task automatic test_stall();
    int issued;
    bit stalled;
    bus0.inst_end = 10'd3;
    bus0.iter_num = 16'd2;
    bus0.computation_start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      stalled = (c >= 3 && c <= 5);
      bus0.stall = stalled;
      #1;
      issued = (c <= 2) ? c - 1 : ((c <= 5) ? 2 : c - 4);
      if (c <= 11) begin
        checks++;
        if (bus0.inst_addr !== 10'(issued % 4) || bus0.iter_cnt !== 16'(issued / 4) ||
            bus0.inst_valid !== !stalled || bus0.pe_array_busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stall_run c=%0d addr=%0d iter=%0d valid=%b busy=%b expected addr=%0d iter=%0d valid=%b busy=1",
                   c, bus0.inst_addr, bus0.iter_cnt, bus0.inst_valid, bus0.pe_array_busy, issued % 4, issued / 4, !stalled);
        end
      end else if (c == 15) begin
        checks++;
        if (bus0.pe_array_busy !== 1'b1 || bus0.computation_done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_drain_end c=%0d busy=%b done=%b expected busy=1 done=0",
                   c, bus0.pe_array_busy, bus0.computation_done);
        end
      end else if (c == 16) begin
        checks++;
        if (bus0.computation_done !== 1'b1 || bus0.pe_array_busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_done c=%0d done=%b busy=%b expected done=1 busy=0",
                   c, bus0.computation_done, bus0.pe_array_busy);
        end
      end
    end
    bus0.computation_start = 1'b0;
    step();
  endtask

  task automatic test_edge_values();
    bus1.inst_end = 10'd0;
    bus1.iter_num = 16'd0;
    bus1.computation_start = 1'b1;
    step();
    checks++;
    if (bus1.inst_valid !== 1'b1 || bus1.inst_addr !== 10'd0 || bus1.iter_cnt !== 16'd0 || bus1.pe_array_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_issue valid=%b addr=%0d iter=%0d busy=%b expected valid=1 addr=0 iter=0 busy=1",
               bus1.inst_valid, bus1.inst_addr, bus1.iter_cnt, bus1.pe_array_busy);
    end
    step();
    checks++;
    if (bus1.computation_done !== 1'b1 || bus1.inst_valid !== 1'b0 || bus1.pe_array_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL edge_done done=%b valid=%b busy=%b expected done=1 valid=0 busy=0",
               bus1.computation_done, bus1.inst_valid, bus1.pe_array_busy);
    end
    bus1.computation_start = 1'b0;
    step();
  endtask

  task automatic test_full_memory();
    bus1.inst_end = 10'd1023;
    bus1.iter_num = 16'd1;
    bus1.computation_start = 1'b1;
    for (int c = 1; c <= 1025; c++) begin
      step();
      if (c == 512 || c == 1024) begin
        checks++;
        if (bus1.inst_addr !== 10'(c - 1) || bus1.inst_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL full_mem_addr c=%0d addr=%0d valid=%b expected addr=%0d valid=1",
                   c, bus1.inst_addr, bus1.inst_valid, c - 1);
        end
      end else if (c == 1025) begin
        checks++;
        if (bus1.computation_done !== 1'b1 || bus1.inst_addr !== 10'd0 || bus1.inst_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL full_mem_done done=%b addr=%0d valid=%b expected done=1 addr=0 valid=0",
                   bus1.computation_done, bus1.inst_addr, bus1.inst_valid);
        end
      end
    end
    bus1.computation_start = 1'b0;
    step();
  endtask

  task automatic test_abort();
    bit saw_done;
    bus0.inst_end = 10'd3;
    bus0.iter_num = 16'd2;
    bus0.computation_start = 1'b1;
    for (int c = 1; c <= 5; c++) step();
    checks++;
    if (bus0.inst_addr !== 10'd0 || bus0.iter_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL abort_pre addr=%0d iter=%0d expected addr=0 iter=1", bus0.inst_addr, bus0.iter_cnt);
    end
    bus0.computation_start = 1'b0;
    step();
    checks++;
    if (bus0.pe_array_busy !== 1'b0 || bus0.inst_addr !== 10'd0 || bus0.iter_cnt !== 16'd0 ||
        bus0.inst_valid !== 1'b0 || bus0.computation_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle busy=%b addr=%0d iter=%0d valid=%b done=%b expected all 0",
               bus0.pe_array_busy, bus0.inst_addr, bus0.iter_cnt, bus0.inst_valid, bus0.computation_done);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus0.computation_done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_done saw_done=%b expected 0", saw_done);
    end
    bus0.inst_end = 10'd1;
    bus0.iter_num = 16'd1;
    bus0.computation_start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c <= 2) begin
        checks++;
        if (bus0.inst_addr !== 10'(c - 1) || bus0.inst_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL restart_addr c=%0d addr=%0d valid=%b expected addr=%0d valid=1",
                   c, bus0.inst_addr, bus0.inst_valid, c - 1);
        end
      end else if (c == 7) begin
        checks++;
        if (bus0.computation_done !== 1'b1) begin
          errors++;
          $display("[TB] FAIL restart_done done=%b expected 1", bus0.computation_done);
        end
      end
    end
    bus0.computation_start = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_drain();
    bus0.inst_end = 10'd0;
    bus0.iter_num = 16'd3;
    bus0.computation_start = 1'b1;
    for (int c = 1; c <= 5; c++) step();
    checks++;
    if (bus0.pe_array_busy !== 1'b1 || bus0.inst_valid !== 1'b0 || bus0.iter_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL drain_pre_reset busy=%b valid=%b iter=%0d expected busy=1 valid=0 iter=2",
               bus0.pe_array_busy, bus0.inst_valid, bus0.iter_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus0.inst_addr, bus0.iter_cnt, bus0.inst_valid, bus0.pe_array_busy, bus0.computation_done} !== 29'd0) begin
      errors++;
      $display("[TB] FAIL async_reset addr=%0d iter=%0d valid=%b busy=%b done=%b expected all 0",
               bus0.inst_addr, bus0.iter_cnt, bus0.inst_valid, bus0.pe_array_busy, bus0.computation_done);
    end
    bus0.computation_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_input_change();
    bus0.inst_end = 10'd1;
    bus0.iter_num = 16'd2;
    bus0.computation_start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) begin
        bus0.inst_end = 10'd7;
        bus0.iter_num = 16'd9;
      end
      if (c <= 4) begin
        checks++;
        if (bus0.inst_addr !== 10'((c - 1) % 2) || bus0.iter_cnt !== 16'((c - 1) / 2) || bus0.inst_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL latched_run c=%0d addr=%0d iter=%0d valid=%b expected addr=%0d iter=%0d valid=1",
                   c, bus0.inst_addr, bus0.iter_cnt, bus0.inst_valid, (c - 1) % 2, (c - 1) / 2);
        end
      end else if (c == 9 || c == 12) begin
        checks++;
        if (bus0.computation_done !== 1'b1 || bus0.pe_array_busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL held_done c=%0d done=%b busy=%b expected done=1 busy=0",
                   c, bus0.computation_done, bus0.pe_array_busy);
        end
      end
    end
    bus0.computation_start = 1'b0;
    step();
    bus0.computation_start = 1'b1;
    step();
    step();
    checks++;
    if (bus0.pe_array_busy !== 1'b1 || bus0.inst_addr !== 10'd1) begin
      errors++;
      $display("[TB] FAIL second_run busy=%b addr=%0d expected busy=1 addr=1",
               bus0.pe_array_busy, bus0.inst_addr);
    end
    bus0.computation_start = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_edge_values();
    test_full_memory();
    test_abort();
    test_reset_mid_drain();
    test_input_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cgra_exec_ctrl.md
# cgra_exec_ctrl

Execution sequencer for the SCGRA PE array. Accepts the software Computation_Start/Computation_Done level handshake and steps the shared instruction address over the kernel body for a programmed number of iterations. It then waits out the PE pipeline drain and drives PE_Array_Busy to the BRAM interface. It sits between the host handshake and the Torus PE array, and owns the instruction-address counter that all PEs share.

## Interface
- IADDR_WIDTH, 10, instruction-memory address width (depth 1024)
- ITER_WIDTH, 16, iteration counter width
- DRAIN_CYCLES, 4, cycles waited after the last instruction issue before Done (0 allowed)
- Clk  input  1  system clock; sole clock
- Resetn  input  1  asynchronous, active-low reset
- Computation_Start  input  1  level from software; held high until Computation_Done is seen
- Inst_End  input  IADDR_WIDTH  last instruction address, inclusive; sampled on start
- Iter_Num  input  ITER_WIDTH  number of kernel iterations; 0 is treated as 1; sampled on start
- Stall  input  1  pauses instruction issue while high
- Inst_Addr  output  IADDR_WIDTH  current instruction address to all PEs
- Inst_Valid  output  1  PE execute enable for Inst_Addr
- Iter_Cnt  output  ITER_WIDTH  current iteration index, starting at 0
- PE_Array_Busy  output  1  high in RUN and DRAIN
- Computation_Done  output  1  high in DONE

## Operation
- States and exits:
  - IDLE: on Computation_Start=1, go to RUN. Latch Inst_End and Iter_Num (0→1). Clear Inst_Addr and Iter_Cnt.
  - RUN: exits described below.
  - DRAIN: counts DRAIN_CYCLES cycles; Stall is ignored. Then go to DONE.
  - DONE: Computation_Done=1 and PE_Array_Busy=0. On Computation_Start=0, go to IDLE.
- RUN, Stall=0: Inst_Valid=1. On the clock edge:
  - If Inst_Addr≠End: Inst_Addr+1.
  - Else, if Iter_Cnt≠Iter_Num−1: Inst_Addr←0 and Iter_Cnt+1.
  - Else: Inst_Addr←0 and go to DRAIN. If DRAIN_CYCLES=0, go directly to DONE.
- RUN, Stall=1: Inst_Valid=0. Inst_Addr, Iter_Cnt and state hold.
- Abort: Computation_Start=0 while in RUN or DRAIN forces IDLE on the next edge.
  - Counters clear.
  - Computation_Done is never asserted for an aborted run.
- In IDLE, Inst_End and Iter_Num changes are ignored. They are also ignored at any time after latching.
- Inst_End=0 gives one instruction per iteration; Inst_End=2^IADDR_WIDTH−1 gives the full memory.
- Counters compare against latched values only. Inst_Addr never wraps past Inst_End, and Iter_Cnt never exceeds Iter_Num−1.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE.
  - Inst_Addr=0, Iter_Cnt=0, drain counter=0.
  - Inst_Valid=0, PE_Array_Busy=0, Computation_Done=0.
- Inst_Addr, Iter_Cnt, state and drain counter are registered.
- Inst_Valid = (state==RUN) & ~Stall, combinational.
- PE_Array_Busy and Computation_Done are decoded from the state register.
- Start sampled high at edge k: RUN from cycle k+1. Inst_Addr=0 and Busy=1 in cycle k+1.
- Stall-free run length:
  - RUN for (Inst_End+1)·Iter_Num cycles.
  - Then DRAIN for DRAIN_CYCLES cycles.
  - Then Done in the following cycle.
- In DONE, Start sampled low at edge m: Done=0 and state IDLE from cycle m+1.
  - A new Start can be accepted at edge m+1 at the earliest.
- Start already high again while in DONE has no effect. A low level must be seen first.

## Test plan
- Basic run. Inst_End=3, Iter_Num=2, DRAIN=4, Stall=0, Start rises before edge 0.
  - Cycles 1–8: Inst_Addr 0,1,2,3,0,1,2,3 with Valid=1; Iter_Cnt 0 in cycles 1–4, 1 in cycles 5–8.
  - Cycles 9–12: Busy=1, Valid=0.
  - Cycle 13: Done=1, Busy=0. Start low → Done=0 next cycle.
- Stall. Same setup with Stall=1 during cycles 3–5.
  - Inst_Addr holds at 2 with Valid=0 during the stall.
  - Sequence resumes unchanged; Done asserts at cycle 16.
- Edge values. Iter_Num=0, Inst_End=0, DRAIN=0.
  - Exactly one Valid cycle with Inst_Addr=0.
  - Done in the very next cycle.
- Abort. Start dropped at cycle 5 of the basic run.
  - IDLE from cycle 6: Busy=0, Inst_Addr=0, Iter_Cnt=0, Done never high.
  - A restart then runs correctly from address 0.
- Async reset mid-DRAIN: Resetn low → all outputs 0 immediately, without waiting for a clock.
- Input change after latch. Inst_End and Iter_Num are changed during RUN, and Start is kept high in DONE.
  - The run still uses the latched values.
  - No second run begins until Start has gone low and high again.
